// File: rtl/regfile_multiport_if.sv
// Register file access bundle: two async read ports, two writeback ports,
// one reserve port, plus the registered busy count.
interface regfile_multiport_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              read_busy1;
  logic              read_busy2;
  logic              write_enable0;
  logic [ADDR_W-1:0] write_reg0;
  logic [DATA_W-1:0] write_data0;
  logic              write_enable1;
  logic [ADDR_W-1:0] write_reg1;
  logic [DATA_W-1:0] write_data1;
  logic              reserve_enable;
  logic [ADDR_W-1:0] reserve_reg;
  logic [ADDR_W:0]   busy_count;

  modport slave (
    input  read_reg1, read_reg2,
    output read_data1, read_data2, read_busy1, read_busy2,
    input  write_enable0, write_reg0, write_data0,
    input  write_enable1, write_reg1, write_data1,
    input  reserve_enable, reserve_reg,
    output busy_count
  );

  modport master (
    output read_reg1, read_reg2,
    input  read_data1, read_data2, read_busy1, read_busy2,
    output write_enable0, write_reg0, write_data0,
    output write_enable1, write_reg1, write_data1,
    output reserve_enable, reserve_reg,
    input  busy_count
  );
endinterface

// File: rtl/regfile_multiport.sv
// Multiport register file with per-register busy scoreboard.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_multiport #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input logic                 clk,
  input logic                 reset,
  regfile_multiport_if.slave  bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [NUM_REGS-1:0] wr_sel0;
  logic [NUM_REGS-1:0] wr_sel1;
  logic [NUM_REGS-1:0] rsv_sel;
  logic [ADDR_W:0]     busy_count_q;

  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) c = c + (ADDR_W+1)'(v[i]);
    return c;
  endfunction

  // One-hot selects; r0 is masked out entirely when hard-wired to zero.
  always_comb begin
    wr_sel0 = '0;
    wr_sel1 = '0;
    rsv_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel0[i] = bus.write_enable0  && (bus.write_reg0  == ADDR_W'(i));
      wr_sel1[i] = bus.write_enable1  && (bus.write_reg1  == ADDR_W'(i));
      rsv_sel[i] = bus.reserve_enable && (bus.reserve_reg == ADDR_W'(i));
    end
    if (ZERO_REG != 0) begin
      wr_sel0[0] = 1'b0;
      wr_sel1[0] = 1'b0;
      rsv_sel[0] = 1'b0;
    end
  end

  // A same-edge reserve marks a newer producer, so it overrides the write's clear.
  assign busy_nxt = (busy & ~(wr_sel0 | wr_sel1)) | rsv_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy         <= '0;
      busy_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel1[i])      regs[i] <= bus.write_data1;
        else if (wr_sel0[i]) regs[i] <= bus.write_data0;
      end
      busy         <= busy_nxt;
      busy_count_q <= popcount(busy_nxt);
    end
  end

  assign bus.busy_count = busy_count_q;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bsy;

    assign addr = (p == 0) ? bus.read_reg1 : bus.read_reg2;

    always_comb begin
      data = regs[addr];
      bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
      if (!reset && (wr_sel0[addr] || wr_sel1[addr])) begin
        data = wr_sel1[addr] ? bus.write_data1 : bus.write_data0;
        bsy  = rsv_sel[addr];
      end
`endif
      if (ZERO_REG != 0 && addr == '0) begin
        data = '0;
        bsy  = 1'b0;
      end
    end
  end

  assign bus.read_data1 = g_rd[0].data;
  assign bus.read_data2 = g_rd[1].data;
  assign bus.read_busy1 = g_rd[0].bsy;
  assign bus.read_busy2 = g_rd[1].bsy;
endmodule
